remote_throw_rx: RTL and testbench

Receive side of the inter-board turn link. Consumes the byte stream from the UART receiver and decodes 3-byte throw frames sent by the remote board's turn controller. Reconstructs the remote player's `index` (sprite/pose select) and `throw_enable` (projectile launch) for the local renderer and physics. Active only while it is the remote player's turn.

---
 rtl/cvd_link_pkg.sv | 30 +++
 rtl/link_frame_parser.sv | 77 +++++++
 rtl/remote_throw_rx.sv | 104 ++++++++++
 tb/tb_remote_throw_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cvd_link_pkg.sv
// Shared definitions for the inter-board turn link: framing constants,
// pose encodings, timing defaults and FSM state encodings.
package cvd_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [3:0] CMD_TYPE  = 4'h3;

  localparam logic [1:0] IDX_IDLE  = 2'd0;
  localparam logic [1:0] IDX_AIM   = 2'd1;
  localparam logic [1:0] IDX_THROW = 2'd2;

  localparam int unsigned DEFAULT_HOLD_CYCLES    = 65_000_000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 650_000;

  typedef logic [1:0] parser_state_t;
  localparam parser_state_t PS_WAIT_SYNC = 2'd0;
  localparam parser_state_t PS_WAIT_CMD  = 2'd1;
  localparam parser_state_t PS_WAIT_CHK  = 2'd2;

  typedef logic [1:0] out_state_t;
  localparam out_state_t OS_IDLE    = 2'd0;
  localparam out_state_t OS_HOLD    = 2'd1;
  localparam out_state_t OS_RELEASE = 2'd2;

  // Index value 3 is reserved and never a legal command.
  function automatic logic cmd_is_legal(input logic [7:0] cmd);
    return (cmd[7:4] == CMD_TYPE) && (cmd[3:2] == 2'b00) && (cmd[1:0] != 2'd3);
  endfunction

endpackage

// File: rtl/link_frame_parser.sv
// Decodes SYNC/CMD/CHK frames from the UART byte stream; flags checksum,
// command and inter-byte timeout errors. Outputs are combinational strobes.
module link_frame_parser
  import cvd_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic [1:0] cmd_index,
  output logic       err
);

  parser_state_t state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [31:0]   gap_q, gap_d;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    gap_d     = gap_q;
    cmd_valid = 1'b0;
    cmd_index = cmd_q[1:0];
    err       = 1'b0;
    if (!enable) begin
      state_d = PS_WAIT_SYNC;
      cmd_d   = 8'h00;
      gap_d   = 32'd0;
    end else if (rx_valid) begin
      // A byte always beats a coincident timeout expiry.
      gap_d = 32'd0;
      unique case (state_q)
        PS_WAIT_SYNC: begin
          if (rx_data == SYNC_BYTE) state_d = PS_WAIT_CMD;
        end
        PS_WAIT_CMD: begin
          cmd_d   = rx_data;
          state_d = PS_WAIT_CHK;
        end
        PS_WAIT_CHK: begin
          state_d = PS_WAIT_SYNC;
          if ((rx_data == (SYNC_BYTE ^ cmd_q)) && cmd_is_legal(cmd_q)) begin
            cmd_valid = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        default: state_d = PS_WAIT_SYNC;
      endcase
    end else if (state_q != PS_WAIT_SYNC) begin
      if (gap_q < 32'(TIMEOUT_CYCLES - 1)) begin
        gap_d = gap_q + 32'd1;
      end else begin
        err     = 1'b1;
        state_d = PS_WAIT_SYNC;
        gap_d   = 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PS_WAIT_SYNC;
      cmd_q   <= 8'h00;
      gap_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: rtl/remote_throw_rx.sv
// Receive side of the turn link: turns decoded frames into the remote
// player's pose index and a fixed-length throw_enable pulse.
module remote_throw_rx
  import cvd_link_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       whose_turn,
  output logic [1:0] index,
  output logic       throw_enable,
  output logic       frame_err
);

  logic       cmd_valid;
  logic [1:0] cmd_index;
  logic       parse_err;

  link_frame_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_parser (
    .clk      (clk),
    .rst      (rst),
    .enable   (whose_turn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_valid(cmd_valid),
    .cmd_index(cmd_index),
    .err      (parse_err)
  );

  out_state_t  state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  index_q, index_d;
  logic        throw_q, throw_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    index_d = index_q;
    throw_d = throw_q;
    err_d   = parse_err;
    if (!whose_turn) begin
      state_d = OS_IDLE;
      hold_d  = 32'd0;
      index_d = IDX_IDLE;
      throw_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        OS_IDLE: begin
          if (cmd_valid) begin
            index_d = cmd_index;
            if (cmd_index == IDX_THROW) begin
              throw_d = 1'b1;
              hold_d  = 32'd0;
              state_d = OS_HOLD;
            end
          end
        end
        // Commands decoded while holding or releasing are dropped.
        OS_HOLD: begin
          if (hold_q < 32'(HOLD_CYCLES - 1)) begin
            hold_d = hold_q + 32'd1;
          end else begin
            throw_d = 1'b0;
            state_d = OS_RELEASE;
          end
        end
        OS_RELEASE: begin
          index_d = IDX_IDLE;
          state_d = OS_IDLE;
        end
        default: state_d = OS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OS_IDLE;
      hold_q  <= 32'd0;
      index_q <= IDX_IDLE;
      throw_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      index_q <= index_d;
      throw_q <= throw_d;
      err_q   <= err_d;
    end
  end

  assign index        = index_q;
  assign throw_enable = throw_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_remote_throw_rx.sv
// Directed plus randomized bench for remote_throw_rx against a byte-level
// reference model of the link protocol.
module tb_remote_throw_rx;

  localparam int unsigned HOLD = 10;
  localparam int unsigned TMO  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       whose_turn;
  logic [1:0] index;
  logic       throw_enable;
  logic       frame_err;

  remote_throw_rx #(
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .whose_turn  (whose_turn),
    .index       (index),
    .throw_enable(throw_enable),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes collected since SYNC, idle gap, remaining throw time.
  logic [7:0] frame_q[$];
  int  m_gap, m_hold_left, m_idx;
  bit  m_rel, m_err;
  int  cnt_thr, cnt_idx2, cnt_err;

  task automatic model_reset();
    frame_q.delete();
    m_gap = 0; m_hold_left = 0; m_idx = 0; m_rel = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit turn);
    int cmd_idx;
    logic [7:0] c;
    cmd_idx = -1;
    m_err   = 0;
    if (!turn) begin
      model_reset();
      return;
    end
    if (v) begin
      m_gap = 0;
      if (frame_q.size() == 0) begin
        if (d == 8'hA5) frame_q.push_back(d);
      end else if (frame_q.size() == 1) begin
        frame_q.push_back(d);
      end else begin
        c = frame_q[1];
        if (d == (8'hA5 ^ c) && c[7:4] == 4'h3 && c[3:2] == 2'b00 && c[1:0] != 2'd3)
          cmd_idx = int'(c[1:0]);
        else
          m_err = 1;
        frame_q.delete();
      end
    end else if (frame_q.size() > 0) begin
      m_gap++;
      if (m_gap == TMO) begin
        m_err = 1;
        m_gap = 0;
        frame_q.delete();
      end
    end
    if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_rel = 1;
    end else if (m_rel) begin
      m_rel = 0;
      m_idx = 0;
    end else if (cmd_idx >= 0) begin
      m_idx = cmd_idx;
      if (cmd_idx == 2) m_hold_left = HOLD;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit turn);
    rx_valid   = v;
    rx_data    = d;
    whose_turn = turn;
    model_step(v, d, turn);
    @(posedge clk);
    #1;
    check("index", 32'(index), 32'(m_idx));
    check("throw_enable", 32'(throw_enable), 32'(m_hold_left > 0));
    check("frame_err", 32'(frame_err), 32'(m_err));
    if (throw_enable) cnt_thr++;
    if (index == 2'd2) cnt_idx2++;
    if (frame_err) cnt_err++;
  endtask

  task automatic idle_t(input int n, input bit turn);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, turn);
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    cyc(1'b1, b0, 1'b1);
    cyc(1'b1, b1, 1'b1);
    cyc(1'b1, b2, 1'b1);
  endtask

  initial begin
    logic [7:0] bytes3[3];
    logic [7:0] cmd;
    int kind, gap;
    bit turn;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; whose_turn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_index", 32'(index), 32'd0);
    check("reset_throw", 32'(throw_enable), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    model_reset();
    idle_t(2, 1'b1);

    // Aim frame
    send3(8'hA5, 8'h31, 8'h94);
    check("aim_index", 32'(index), 32'd1);
    check("aim_throw", 32'(throw_enable), 32'd0);

    // Throw frame: hold length and index-2 duration
    cnt_thr = 0; cnt_idx2 = 0;
    send3(8'hA5, 8'h32, 8'h97);
    idle_t(15, 1'b1);
    check("throw_len", 32'(cnt_thr), HOLD);
    check("idx2_len", 32'(cnt_idx2), HOLD + 1);
    check("post_throw_index", 32'(index), 32'd0);

    // Bad checksum leaves index alone
    send3(8'hA5, 8'h31, 8'h94);
    cnt_err = 0;
    send3(8'hA5, 8'h31, 8'h00);
    idle_t(2, 1'b1);
    check("bad_chk_err", 32'(cnt_err), 32'd1);
    check("bad_chk_index", 32'(index), 32'd1);

    // Junk ahead of SYNC is silent
    cnt_err = 0;
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'hFF, 1'b1);
    send3(8'hA5, 8'h30, 8'h95);
    check("junk_err", 32'(cnt_err), 32'd0);
    check("junk_index", 32'(index), 32'd0);

    // Inter-byte timeout then recovery
    cnt_err = 0;
    cyc(1'b1, 8'hA5, 1'b1);
    idle_t(15, 1'b1);
    check("timeout_early", 32'(cnt_err), 32'd0);
    idle_t(10, 1'b1);
    check("timeout_err", 32'(cnt_err), 32'd1);
    send3(8'hA5, 8'h31, 8'h94);
    check("after_timeout_index", 32'(index), 32'd1);

    // Frame during HOLD is discarded
    cnt_thr = 0;
    send3(8'hA5, 8'h32, 8'h97);
    send3(8'hA5, 8'h31, 8'h94);
    idle_t(15, 1'b1);
    check("hold_ignore_len", 32'(cnt_thr), HOLD);
    check("hold_ignore_index", 32'(index), 32'd0);

    // Turn loss truncates hold
    send3(8'hA5, 8'h32, 8'h97);
    idle_t(3, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check("trunc_throw", 32'(throw_enable), 32'd0);
    check("trunc_index", 32'(index), 32'd0);

    // Bytes ignored when it is not the remote turn
    cnt_err = 0;
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 8'h32, 1'b0);
    cyc(1'b1, 8'h97, 1'b0);
    idle_t(2, 1'b1);
    check("offturn_index", 32'(index), 32'd0);
    check("offturn_throw", 32'(throw_enable), 32'd0);
    check("offturn_err", 32'(cnt_err), 32'd0);

    // Randomized frames: good, corrupt, junk, timeouts, turn drops
    for (int f = 0; f < 80; f++) begin
      kind = $urandom_range(0, 9);
      turn = ($urandom_range(0, 15) != 0);
      cmd  = 8'h30 | 8'($urandom_range(0, 2));
      if (kind == 0) cmd = 8'($urandom);
      bytes3[0] = 8'hA5;
      bytes3[1] = cmd;
      bytes3[2] = (kind == 1) ? 8'($urandom) : (8'hA5 ^ cmd);
      if (kind == 2) cyc(1'b1, 8'($urandom), turn);
      for (int i = 0; i < 3; i++) begin
        gap = (kind == 3 && i == 1) ? int'(TMO) + 2 : int'($urandom_range(0, 2));
        idle_t(gap, turn);
        cyc(1'b1, bytes3[i], turn);
      end
      if (kind == 4) idle_t(int'(HOLD) / 2, 1'b1);
    end
    idle_t(2 * int'(HOLD), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
